hilo_muldiv: RTL
================

// Module: hilo_muldiv
// PURPOSE
// EX-stage multiply/divide unit owning the HI/LO registers. Executes mult/multu/div/divu
// over a fixed multi-cycle latency, applies mthi/mtlo writes, and undoes an mthi/mtlo
// write when the MEM-stage interrupt logic raises remthi/remtlo.
// Its busy output is the stall source for md/mf/mt instructions in EX.
// PARAMETERS
// MULT_CYCLES  5   busy cycles for mult/multu (legal 1..15)
// DIV_CYCLES   10  busy cycles for div/divu (legal 1..15)
// PORTS
// clk      in   1   single clock, rising edge
// reset_n  in   1   asynchronous, active-low reset
// start    in   1   EX holds a md instruction this cycle
// md_op    in   3   0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu (4/5 need MADD_EN)
// A        in   32  rs operand (dividend / multiplicand)
// B        in   32  rt operand (divisor / multiplier)
// mthi     in   1   EX holds mthi; HI <= wdata
// mtlo     in   1   EX holds mtlo; LO <= wdata
// wdata    in   32  rs value for mthi/mtlo
// IntReq   in   1   interrupt/exception taken this cycle; EX instruction is flushed
// remthi   in   1   MEM-stage mthi is being cancelled; restore HI
// remtlo   in   1   MEM-stage mtlo is being cancelled; restore LO
// busy     out  1   start | (state != IDLE); combinational
// HI       out  32  HI register
// LO       out  32  LO register
// BEHAVIOUR
// - Reset (async, reset_n=0): HI=LO=0, hi_bak=lo_bak=0, state=IDLE, cnt=0; busy=start.
// - FSM IDLE/MUL/DIV. IDLE & start & !IntReq: latch A,B,md_op; go MUL (ops 0,1,4,5) or
//   DIV (2,3); cnt <= N-1 (N = MULT_CYCLES or DIV_CYCLES).
// - MUL/DIV: cnt decrements each cycle; on the cycle cnt==0 write HI/LO at that edge, go IDLE.
//   The first start edge is busy cycle 1, so busy is high N+1 consecutive cycles incl. start cycle;
//   HI/LO show the new value on the cycle busy first falls.
// - mult: {HI,LO} = signed 64b product; multu: unsigned. div: LO=quot, HI=rem,
//   truncating toward zero, rem takes dividend's sign; divu unsigned.
// - B==0 for div/divu: full latency runs, HI/LO left unchanged.
// - start while state!=IDLE: ignored (pipeline stalls on busy; never legal).
// - mthi (mtlo) in IDLE & !IntReq: hi_bak<=HI, HI<=wdata (lo_bak/LO likewise), one edge.
//   mthi/mtlo while state!=IDLE: ignored.
// - remthi: HI <= hi_bak at the edge; remtlo: LO <= lo_bak. Arrives exactly one cycle after
//   the mt write (instruction now in MEM). Restore has priority over mthi/mtlo/result writes.
// - IntReq suppresses start, mthi, mtlo of the same cycle (flushed EX instruction).
//   An operation already in MUL/DIV is not aborted; it completes and writes HI/LO.
// - hi_bak/lo_bak are touched only by mthi/mtlo; md results do not update them.
// - Reset mid-operation: FSM to IDLE, result discarded, HI/LO cleared.
// CONFIGURATION
// - MADD_EN defined: md_op 4 (madd) / 5 (maddu) do {HI,LO} <= {HI,LO} + product (signed /
//   unsigned), 64b wrap-around, accumulation uses HI/LO at the completion edge.
// - MADD_EN undefined: md_op 4..7 treated as no-op; start with them sets no busy, HI/LO untouched.
// - md_op 6,7: no-op in both builds.
// TESTING
// - reset_n=0 mid-DIV -> busy=0, HI=LO=0 immediately (async), FSM IDLE after release.
// - mult A=-3 B=7 -> busy high 6 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
// - div A=-7 B=2 -> after 11 busy cycles LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; divu A=7 B=0 -> HI/LO unchanged.
// - HI=5; mthi wdata=9 -> HI=9 next edge; remthi next cycle -> HI=5; mtlo w/o remtlo -> LO keeps wdata.
// - start+IntReq same cycle -> busy deasserts next cycle, HI/LO unchanged; mthi+IntReq -> HI unchanged.
// - MADD_EN: HI=0 LO=32'hFFFFFFFF, maddu A=1 B=1 -> HI=1, LO=0; without MADD_EN -> no change, no busy.

Source files
------------

// File: rtl/hilo_muldiv_if.sv
// Bundles the EX-stage control, operands and HI/LO results of hilo_muldiv.
interface hilo_muldiv_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        IntReq;
    logic        remthi;
    logic        remtlo;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, md_op, A, B, mthi, mtlo, wdata, IntReq, remthi, remtlo,
        input  busy, HI, LO
    );

    modport slave (
        input  start, md_op, A, B, mthi, mtlo, wdata, IntReq, remthi, remtlo,
        output busy, HI, LO
    );
endinterface

// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply/divide unit owning HI/LO, with mthi/mtlo writes that can be undone.
// Define MADD_EN to enable madd/maddu (md_op 4/5), which accumulate into {HI,LO}.
module hilo_muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset_n,
    hilo_muldiv_if.slave md
);

`ifdef MADD_EN
    localparam bit MaddEn = 1'b1;
`else
    localparam bit MaddEn = 1'b0;
`endif

    localparam logic [3:0] MulLoad = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DivLoad = 4'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q;
    logic [31:0] opA_q, opB_q;
    logic [31:0] hi_q, lo_q, hiBak_q, loBak_q;
    logic [31:0] hi_d, lo_d, hiBak_d, loBak_d;
    logic        isMulOp, isDivOp, opValid;
    logic        launch, done, mtAllowed, resValid;
    logic [63:0] prodS, prodU, result;

    always_comb begin
        isMulOp = (md.md_op == 3'd0) || (md.md_op == 3'd1) ||
                  (MaddEn && ((md.md_op == 3'd4) || (md.md_op == 3'd5)));
        isDivOp = (md.md_op == 3'd2) || (md.md_op == 3'd3);
        opValid = isMulOp || isDivOp;
    end

    // The counter is loaded with N-1 so the completion edge is the N-th busy edge after start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        launch  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (md.start && !md.IntReq && opValid) begin
                    launch  = 1'b1;
                    state_d = isDivOp ? DIV : MUL;
                    cnt_d   = isDivOp ? DivLoad : MulLoad;
                end
            end
            MUL, DIV: begin
                if (cnt_q == 4'd0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        prodS = $signed({{32{opA_q[31]}}, opA_q}) * $signed({{32{opB_q[31]}}, opB_q});
        prodU = {32'd0, opA_q} * {32'd0, opB_q};
    end

    // Division by zero leaves HI/LO alone, so the result is flagged invalid.
    always_comb begin
        resValid = 1'b1;
        result   = {hi_q, lo_q};
        case (op_q)
            3'd0: result = prodS;
            3'd1: result = prodU;
            3'd2: begin
                resValid = (opB_q != 32'd0);
                result   = {32'($signed(opA_q) % $signed(opB_q)),
                            32'($signed(opA_q) / $signed(opB_q))};
            end
            3'd3: begin
                resValid = (opB_q != 32'd0);
                result   = {opA_q % opB_q, opA_q / opB_q};
            end
`ifdef MADD_EN
            3'd4: result = {hi_q, lo_q} + prodS;
            3'd5: result = {hi_q, lo_q} + prodU;
`endif
            default: resValid = 1'b0;
        endcase
    end

    // Restores from MEM win over everything else that targets the same register.
    always_comb begin
        mtAllowed = (state_q == IDLE) && !md.IntReq;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hiBak_d   = hiBak_q;
        loBak_d   = loBak_q;
        if (done && resValid) begin
            {hi_d, lo_d} = result;
        end
        if (mtAllowed && md.mthi) begin
            hiBak_d = hi_q;
            hi_d    = md.wdata;
        end
        if (mtAllowed && md.mtlo) begin
            loBak_d = lo_q;
            lo_d    = md.wdata;
        end
        if (md.remthi) hi_d = hiBak_q;
        if (md.remtlo) lo_d = loBak_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            opA_q   <= 32'd0;
            opB_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hiBak_q <= 32'd0;
            loBak_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hiBak_q <= hiBak_d;
            loBak_q <= loBak_d;
            if (launch) begin
                op_q  <= md.md_op;
                opA_q <= md.A;
                opB_q <= md.B;
            end
        end
    end

    assign md.busy = (md.start && opValid) || (state_q != IDLE);
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;

endmodule
